prien_alloc: RTL and testbench
==============================

Name: prien_alloc

Overview:
- Parametrised dual-ended entry allocator for reservation-station, ROB or free-list style structures.
- Holds a DEPTH-bit busy bitmap in flops and priority-encodes the free entries.
- Offers the lowest-index and highest-index free entries every cycle, so up to two entries can be allocated per cycle.
- Entries are released by a bitmask; the whole structure can be flushed in one cycle.

Parameters:
- DEPTH, 32, number of entries; power of two, >= 4.
- IDX_W, 5, index width; must equal log2(DEPTH).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- take_lo  input  1  consume the offered low entry this cycle.
- take_hi  input  1  consume the offered high entry this cycle.
- free_mask  input  DEPTH  entries to release at this edge.
- flush  input  1  release all entries at this edge.
- lo_valid  output  1  low offer is valid.
- lo_idx  output  IDX_W  lowest free entry index.
- hi_valid  output  1  high offer is valid and distinct from the low offer.
- hi_idx  output  IDX_W  highest free entry index.
- free_count  output  IDX_W+1  number of free entries.
- all_busy  output  1  no free entries.
- all_free  output  1  every entry free.
- err  output  1  sticky protocol error; present only with PRIEN_ALLOC_CHECK_EN.

Behaviour:
- State: busy[DEPTH-1:0] and free_count, both registered.
- Reset (async, while asserted): busy = 0, free_count = DEPTH, err = 0.
- Consequently during reset: lo_valid = 1, lo_idx = 0, hi_valid = 1, hi_idx = DEPTH-1, all_free = 1, all_busy = 0.
- Offers are combinational from flops only, with no input-to-output paths:
  - lo_idx = lowest i with busy[i] = 0; hi_idx = highest such i.
  - lo_valid = (free_count >= 1); hi_valid = (free_count >= 2).
  - With no free entry, both indices read 0.
  - With exactly one free entry, lo_idx = hi_idx and hi_valid = 0.
- Handshake: a take is honoured at the edge only when the matching valid is high. take_lo with lo_valid = 0, or take_hi with hi_valid = 0, is ignored (no state change).
- Next state at the rising edge, applied in priority order:
  1. flush: busy = 0, free_count = DEPTH. Takes and free_mask in the same cycle are ignored.
  2. Otherwise: busy_next = (busy & ~free_mask) | honoured takes.
     - free_mask bits on already-free entries are no-ops.
     - Free and take cannot hit the same entry, because offered entries are free.
  3. free_count_next = free_count + popcount(free_mask & busy) - honoured takes. Width IDX_W+1, so there is no wrap; DEPTH is representable.
- Latency:
  - An entry taken at edge N is busy, and no longer offered, from cycle N+1.
  - An entry freed at edge N is offerable from cycle N+1. There is no same-cycle free-to-offer bypass.
- all_busy = (free_count == 0); all_free = (free_count == DEPTH).
- Invariant: free_count always equals the number of zero bits in busy.

Optional Feature:
- Macro PRIEN_ALLOC_CHECK_EN.
- Defined:
  - err port is present.
  - err sets at the edge after any of: free_mask hits an entry with busy = 0; take_lo with lo_valid = 0; take_hi with hi_valid = 0.
  - None of these is checked in a flush cycle.
  - err is sticky; only reset clears it, not flush.
- Undefined: the err port and its logic are absent; the same conditions are silently ignored as described above.

Test Plan (DEPTH = 8, IDX_W = 3):
- Reset release, no stimulus -> lo_idx = 0, hi_idx = 7, lo_valid = hi_valid = 1, free_count = 8, all_free = 1.
- take_lo + take_hi for 3 consecutive cycles:
  - offers seen are (0,7), (1,6), (2,5);
  - afterwards busy = 8'b11100111, free_count = 2, offers (3,4).
- Continuing from 2 free, take_lo + take_hi:
  - free_count = 0, all_busy = 1, lo_valid = hi_valid = 0;
  - a further take_lo changes nothing, and err = 1 with the macro.
- Only entry 5 free: lo_idx = hi_idx = 5, hi_valid = 0; take_hi alone is ignored; take_lo -> all_busy next cycle.
- From all busy, free_mask = 8'h21 with take_lo low:
  - next cycle lo_idx = 0, hi_idx = 5, free_count = 2;
  - then re-free entry 0 -> free_count unchanged, err set with the macro.
- Partial occupancy, then flush together with take_lo and free_mask = 8'hFF -> all_free = 1 and free_count = 8 next cycle; err unchanged.
- Assert reset asynchronously mid-cycle -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/prien_alloc.sv
// Dual-ended free-entry allocator: offers lowest and highest free slot each cycle.
// Optional sticky protocol error output enabled by PRIEN_ALLOC_CHECK_EN.
module prien_alloc #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             take_lo,
    input  logic             take_hi,
    input  logic [DEPTH-1:0] free_mask,
    input  logic             flush,
    output logic             lo_valid,
    output logic [IDX_W-1:0] lo_idx,
    output logic             hi_valid,
    output logic [IDX_W-1:0] hi_idx,
    output logic [IDX_W:0]   free_count,
    output logic             all_busy,
    output logic             all_free
`ifdef PRIEN_ALLOC_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] take_mask;
    logic [DEPTH-1:0] released;
    logic [IDX_W:0]   rel_count;
    logic [IDX_W:0]   fc_next;
    logic             take_lo_ok;
    logic             take_hi_ok;

    assign lo_valid = (free_count >= (IDX_W+1)'(1));
    assign hi_valid = (free_count >= (IDX_W+1)'(2));
    assign all_busy = (free_count == '0);
    assign all_free = (free_count == FULL);

    // Scan direction makes the last hit win: downward gives lowest, upward highest.
    always_comb begin
        lo_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) lo_idx = IDX_W'(i);
        end
    end

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i]) hi_idx = IDX_W'(i);
        end
    end

    assign take_lo_ok = take_lo & lo_valid;
    assign take_hi_ok = take_hi & hi_valid;
    assign released   = free_mask & busy;

    always_comb begin
        rel_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel_count = rel_count + (IDX_W+1)'(released[i]);
        end
    end

    always_comb begin
        take_mask = '0;
        if (take_lo_ok) take_mask[lo_idx] = 1'b1;
        if (take_hi_ok) take_mask[hi_idx] = 1'b1;
    end

    assign busy_next = (busy & ~free_mask) | take_mask;
    assign fc_next   = free_count + rel_count
                     - (IDX_W+1)'(take_lo_ok)
                     - (IDX_W+1)'(take_hi_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            free_count <= FULL;
        end else if (flush) begin
            busy       <= '0;
            free_count <= FULL;
        end else begin
            busy       <= busy_next;
            free_count <= fc_next;
        end
    end

`ifdef PRIEN_ALLOC_CHECK_EN
    logic bad_op;

    assign bad_op = ~flush & ((|(free_mask & ~busy))
                  | (take_lo & ~lo_valid)
                  | (take_hi & ~hi_valid));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bad_op) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_prien_alloc.sv
// Directed-vector bench for prien_alloc at DEPTH = 8.
// Expected values are hand-derived from the allocation sequence below.
module tb_prien_alloc;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clock;
    logic             reset;
    logic             take_lo;
    logic             take_hi;
    logic [DEPTH-1:0] free_mask;
    logic             flush;
    logic             lo_valid;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_valid;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W:0]   free_count;
    logic             all_busy;
    logic             all_free;
`ifdef PRIEN_ALLOC_CHECK_EN
    logic             err;
`endif

    int nvec = 0;
    int nerr = 0;

    prien_alloc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .take_lo    (take_lo),
        .take_hi    (take_hi),
        .free_mask  (free_mask),
        .flush      (flush),
        .lo_valid   (lo_valid),
        .lo_idx     (lo_idx),
        .hi_valid   (hi_valid),
        .hi_idx     (hi_idx),
        .free_count (free_count),
        .all_busy   (all_busy),
        .all_free   (all_free)
`ifdef PRIEN_ALLOC_CHECK_EN
        ,
        .err        (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        take_lo   = 1'b0;
        take_hi   = 1'b0;
        free_mask = '0;
        flush     = 1'b0;
    endtask

    task automatic offers(input string tag, input int lv, input int li,
                          input int hv, input int hi, input int fc);
        check({tag, ".lo_valid"}, 32'(lo_valid), 32'(lv));
        check({tag, ".lo_idx"}, 32'(lo_idx), 32'(li));
        check({tag, ".hi_valid"}, 32'(hi_valid), 32'(hv));
        check({tag, ".hi_idx"}, 32'(hi_idx), 32'(hi));
        check({tag, ".free_count"}, 32'(free_count), 32'(fc));
        check({tag, ".all_busy"}, 32'(all_busy), 32'(fc == 0));
        check({tag, ".all_free"}, 32'(all_free), 32'(fc == DEPTH));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #12;
        offers("in_reset", 1, 0, 1, 7, 8);
        @(negedge clock);
        reset = 1'b0;
        step();
        offers("post_reset", 1, 0, 1, 7, 8);
`ifdef PRIEN_ALLOC_CHECK_EN
        check("post_reset.err", 32'(err), 32'd0);
`endif

        for (int k = 0; k < 3; k++) begin
            offers($sformatf("pair%0d", k), 1, k, 1, 7 - k, 8 - 2 * k);
            take_lo = 1'b1;
            take_hi = 1'b1;
            step();
        end
        idle();
        offers("two_left", 1, 3, 1, 4, 2);

        take_lo = 1'b1;
        take_hi = 1'b1;
        step();
        idle();
        offers("full", 0, 0, 0, 0, 0);
`ifdef PRIEN_ALLOC_CHECK_EN
        check("full.err", 32'(err), 32'd0);
`endif
        take_lo = 1'b1;
        step();
        idle();
        offers("take_on_full", 0, 0, 0, 0, 0);
`ifdef PRIEN_ALLOC_CHECK_EN
        check("take_on_full.err", 32'(err), 32'd1);
`endif

        free_mask = 8'h20;
        step();
        idle();
        offers("one_free", 1, 5, 0, 5, 1);
        take_hi = 1'b1;
        step();
        idle();
        offers("hi_ignored", 1, 5, 0, 5, 1);
        take_lo = 1'b1;
        step();
        idle();
        offers("last_taken", 0, 0, 0, 0, 0);

        free_mask = 8'h21;
        step();
        idle();
        offers("free_21", 1, 0, 1, 5, 2);
        free_mask = 8'h01;
        step();
        idle();
        offers("refree_0", 1, 0, 1, 5, 2);

        // Take entry 0 while releasing 7 in the same edge.
        take_lo   = 1'b1;
        free_mask = 8'h80;
        step();
        idle();
        offers("take_and_free", 1, 5, 1, 7, 2);

        flush     = 1'b1;
        take_lo   = 1'b1;
        free_mask = 8'hFF;
        step();
        idle();
        offers("flush", 1, 0, 1, 7, 8);
`ifdef PRIEN_ALLOC_CHECK_EN
        check("flush.err", 32'(err), 32'd1);
`endif

        take_lo = 1'b1;
        take_hi = 1'b1;
        step();
        take_lo = 1'b1;
        take_hi = 1'b0;
        step();
        idle();
        offers("partial", 1, 2, 1, 6, 5);
        #2;
        reset = 1'b1;
        #1;
        offers("async_reset", 1, 0, 1, 7, 8);
`ifdef PRIEN_ALLOC_CHECK_EN
        check("async_reset.err", 32'(err), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        step();
        offers("after_reset", 1, 0, 1, 7, 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
